present_enc_ctrl: RTL
=====================

// Module: present_enc_ctrl
// PURPOSE
//  Iterative PRESENT-80 encryption sequencer: one round per clock.
//  Drives the existing 64-bit parallel S-box layer and a round counter.
//  Owns the 80-bit key schedule and a start/done handshake.
//  Sits between the host bus regs and the cipher datapath; one block in flight at a time.
// PARAMETERS
//  ROUNDS  31  rounds before final whitening; 1..31, counter is 5 bits; reduce only for debug
//  KEY_W   80  key width; only 80 supported, enforced by elaboration-time check
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      request; sampled only when busy==0
//  plaintext   in   64     sampled on the accepting edge
//  key         in   KEY_W  sampled on the accepting edge
//  busy        out  1      high from the accept edge until the edge after the last round
//  done        out  1      one-cycle pulse, ciphertext valid
//  ciphertext  out  64     held until the next done
// BEHAVIOUR
//  Reset (async, active-high): FSM=IDLE, busy=0, done=0, ciphertext=0, state/key/round regs=0.
//  FSM states:
//   IDLE: start=1 -> latch st=plaintext, k=key, rc=1, busy=1, go RUN.
//   RUN: each edge
//    - st <= P(S(st ^ k[79:16]));
//    - k <= KS(k, rc), rc <= rc+1.
//    - On the edge where rc==ROUNDS: ciphertext <= P(S(st^k[79:16])) ^ KS(k,rc)[79:16];
//      done <= 1, busy <= 0, go IDLE.
//  KS(k,rc):
//   - r = k rotated left 61;
//   - r[79:76] = sbox(r[79:76]);
//   - r[19:15] ^= rc[4:0].
//  P: bit i -> position (16*i) mod 63; bit 63 fixed.
//  Latency: start accepted at edge E0; done high in the cycle after edge E0+ROUNDS
//   (32 cycles for ROUNDS=31).
//  done is registered and lasts exactly one cycle.
//  The done cycle is IDLE, so start may be accepted there (back-to-back throughput 1/ROUNDS+1).
//  start while busy=1: ignored, no effect on state or inputs.
//  plaintext/key changes after the accept edge: no effect.
//  Reset mid-operation: aborts immediately; no done pulse; ciphertext returns to 0.
//  Illegal FSM encoding: next state IDLE, busy=0.
// STRUCTURE
//  present_pkg holds:
//   - FSM state localparams IDLE/RUN;
//   - constant PRESENT_ROUNDS=31;
//   - function p_layer(64b);
//   - function key_update(80b, 5b).
//  Instantiates the existing 64-bit parallel S-box layer for the state datapath.
//  One natural sub-module: present_key_schedule.
//   - Comb: k_in, rc -> k_out.
//   - Uses one 4-bit present sbox instance.
//  Controller FSM, round counter and registers stay in present_enc_ctrl.
// TESTING
//  1. pt=0, key=0, start 1 cycle -> done at cycle 32, ct=64'h5579C1387B228445.
//  2. pt=0, key=80'hFFFF_FFFF_FFFF_FFFF_FFFF -> ct=64'hE72C46C0F5945049.
//  3. pt=64'hFFFF_FFFF_FFFF_FFFF, key=0 -> ct=64'hA112FFC72F68417B.
//     Then start in the done cycle with pt=all-F, key=all-F -> next ct=64'h3333DCD3213210D2, 32 cycles later.
//  4. Start held high and inputs toggled during busy:
//     - exactly one done per accepted request;
//     - ct matches the inputs sampled at accept.
//  5. Assert rst at cycle 10 of a run:
//     - busy/done/ct drop to 0 asynchronously, with no done pulse;
//     - after release, start with vector 1 gives the same ct.
//  6. ROUNDS=1 build: pt=0, key=0 -> done 2 cycles after accept, ct = P(S(0)) ^ KS(0,1)[79:16].

Source files
------------

// File: rtl/present_enc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// present_enc_ctrl_pkg
//   Shared constants and helper functions for the PRESENT-80 encryption
//   sequencer: FSM state codes, round count, the 4-bit S-box table, the bit
//   permutation layer and the key-schedule update.
// ---------------------------------------------------------------------------
package present_enc_ctrl_pkg;

    // FSM state codes. Two bits are used so that illegal encodings exist and
    // can be steered back to IDLE.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;

    localparam int PRESENT_ROUNDS = 31;
    localparam int BLOCK_W        = 64;
    localparam int KEY_W_C        = 80;

    // PRESENT 4-bit S-box.
    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Bit permutation: bit i moves to (16*i) mod 63; bit 63 stays put.
    function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[(16 * i) % 63] = x[i];
        end
        y[63] = x[63];
        return y;
    endfunction

    // One key-schedule step: rotate left 61, S-box the top nibble, fold in
    // the round counter at bits 19:15.
    function automatic logic [KEY_W_C-1:0] key_update(input logic [KEY_W_C-1:0] k,
                                                      input logic [4:0]         rc);
        logic [KEY_W_C-1:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox4(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

endpackage

// File: rtl/present_enc_ctrl_if.sv
// ---------------------------------------------------------------------------
// present_enc_ctrl_if
//   Host-side handshake and data bus of the PRESENT-80 sequencer.
//   start      host -> core  request, honoured only while busy is low
//   plaintext  host -> core  64-bit block, captured on the accepting edge
//   key        host -> core  80-bit key, captured on the accepting edge
//   busy       core -> host  block in flight
//   done       core -> host  one-cycle pulse, ciphertext valid
//   ciphertext core -> host  result, held until the next done
// ---------------------------------------------------------------------------
interface present_enc_ctrl_if;
    import present_enc_ctrl_pkg::*;

    logic                 start;
    logic [BLOCK_W-1:0]   plaintext;
    logic [KEY_W_C-1:0]   key;
    logic                 busy;
    logic                 done;
    logic [BLOCK_W-1:0]   ciphertext;

    modport master (output start, plaintext, key, input  busy, done, ciphertext);
    modport slave  (input  start, plaintext, key, output busy, done, ciphertext);
endinterface

// File: rtl/present_key_schedule.sv
// ---------------------------------------------------------------------------
// present_key_schedule
//   Combinational PRESENT-80 key update for one round.
//   k_in   in  80  current key register
//   rc     in  5   round counter of the round being executed
//   k_out  out 80  key for the following round
// ---------------------------------------------------------------------------
module present_key_schedule
    import present_enc_ctrl_pkg::*;
(
    input  logic [KEY_W_C-1:0] k_in,
    input  logic [4:0]         rc,
    output logic [KEY_W_C-1:0] k_out
);
    logic [KEY_W_C-1:0] rot;
    logic [3:0]         top_sb;

    // Rotate left by 61 == rotate right by 19.
    assign rot = {k_in[18:0], k_in[79:19]};

    present_sbox u_sbox (
        .din  (rot[79:76]),
        .dout (top_sb)
    );

    assign k_out = {top_sb, rot[75:20], rot[19:15] ^ rc, rot[14:0]};
endmodule

// File: rtl/present_sbox.sv
// ---------------------------------------------------------------------------
// present_sbox
//   Single 4-bit PRESENT S-box, purely combinational.
//   din   in  4  nibble in
//   dout  out 4  substituted nibble
// ---------------------------------------------------------------------------
module present_sbox
    import present_enc_ctrl_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = sbox4(din);
endmodule

// File: rtl/present_sbox_layer.sv
// ---------------------------------------------------------------------------
// present_sbox_layer
//   64-bit parallel substitution layer: sixteen 4-bit S-boxes side by side.
//   din   in  64  state after round-key addition
//   dout  out 64  substituted state
// ---------------------------------------------------------------------------
module present_sbox_layer
    import present_enc_ctrl_pkg::*;
(
    input  logic [BLOCK_W-1:0] din,
    output logic [BLOCK_W-1:0] dout
);
    for (genvar g = 0; g < BLOCK_W / 4; g++) begin : g_nib
        present_sbox u_sbox (
            .din  (din [4*g +: 4]),
            .dout (dout[4*g +: 4])
        );
    end
endmodule

// File: rtl/present_enc_ctrl.sv
// ---------------------------------------------------------------------------
// present_enc_ctrl
//   Iterative PRESENT-80 encryption sequencer, one round per clock.
//   Captures plaintext/key on an accepted start, runs ROUNDS rounds through
//   the parallel S-box layer and the key schedule, then applies the final
//   whitening key and pulses done.
//   clk   in          rising-edge clock
//   rst   in          asynchronous active-high reset
//   bus   slave port  start/plaintext/key in, busy/done/ciphertext out
// Parameters
//   ROUNDS  rounds before final whitening (1..31)
//   KEY_W   key width, must be 80
// ---------------------------------------------------------------------------
module present_enc_ctrl
    import present_enc_ctrl_pkg::*;
#(
    parameter int ROUNDS = PRESENT_ROUNDS,
    parameter int KEY_W  = 80
) (
    input  logic              clk,
    input  logic              rst,
    present_enc_ctrl_if.slave bus
);

    if (KEY_W != 80) begin : g_bad_key_w
        $error("present_enc_ctrl: only KEY_W=80 is supported");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_enc_ctrl: ROUNDS must be in 1..31");
    end

    localparam logic [4:0] LAST_RC = 5'(ROUNDS);

    logic [1:0]          state;
    logic [BLOCK_W-1:0]  st;
    logic [KEY_W_C-1:0]  k;
    logic [4:0]          rc;
    logic                busy_q;
    logic                done_q;
    logic [BLOCK_W-1:0]  ct_q;

    logic [BLOCK_W-1:0]  keyed;
    logic [BLOCK_W-1:0]  subst;
    logic [BLOCK_W-1:0]  round_out;
    logic [KEY_W_C-1:0]  k_next;

    // Round datapath: add round key, substitute, permute.
    assign keyed     = st ^ k[79:16];
    assign round_out = p_layer(subst);

    present_sbox_layer u_sbox_layer (
        .din  (keyed),
        .dout (subst)
    );

    present_key_schedule u_key_schedule (
        .k_in  (k),
        .rc    (rc),
        .k_out (k_next)
    );

    // NOTE: every register here is reset, including the datapath state and
    // key, so an aborted block leaves no key material behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            st     <= '0;
            k      <= '0;
            rc     <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ct_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge values of st/k/rc regardless of statement order.
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        st     <= bus.plaintext;
                        k      <= bus.key;
                        rc     <= 5'd1;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    st <= round_out;
                    k  <= k_next;
                    rc <= rc + 5'd1;
                    if (rc == LAST_RC) begin
                        // Final whitening uses the key produced by this round.
                        ct_q   <= round_out ^ k_next[79:16];
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                // NOTE: a default arm recovers illegal encodings instead of
                // leaving the FSM stuck in an unreachable code.
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.ciphertext = ct_q;

endmodule
